// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader and address arbiter for the byte-wide
// instruction memory. Host words arrive over a valid/ready handshake and are
// written most-significant byte first, matching a fetch path that assembles
// {mem[a], mem[a+1], mem[a+2], mem[a+3]}. While a load runs the CPU is stalled
// and the loader owns the memory port; otherwise pc_addr passes straight through.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a load session at byte address 0 (IDLE only)
//   wr_valid/wr_ready host word handshake; wr_word, wr_last = word and end flag
//   pc_addr           CPU fetch address (passed to mem_addr in IDLE)
//   mem_addr/mem_data/mem_we  memory port (memory samples on falling edge)
//   cpu_stall         high for the whole session
//   load_done         one-cycle pulse at the end of a session
//   load_err          sticky overflow flag, cleared by start or reset
//   byte_count        bytes written in the current or last session
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | CPU owns memory, waiting for start
// ACCEPT | wr_ready high, waiting for a host word; overflow checked here
// WRITE  | four cycles, one byte per cycle, MSB first
// DONE   | one-cycle load_done pulse, then back to IDLE
module imem_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 91
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_word,
  input  logic                  wr_last,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  cpu_stall,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH-1:0] byte_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [1:0]            idx;
  logic [31:0]           word_q;
  logic                  last_q;
  logic                  err_q;
  logic [ADDR_WIDTH:0]   ptr_end;
  logic                  overflow;
  logic [7:0]            byte_sel;

  // One extra bit so the end-of-word address cannot wrap before the compare.
  assign ptr_end  = {1'b0, ptr} + (ADDR_WIDTH+1)'(3);
  assign overflow = (ptr_end > LAST_ADDR);

  always_comb begin
    byte_sel = word_q[31:24];
    case (idx)
      2'd0: byte_sel = word_q[31:24];
      2'd1: byte_sel = word_q[23:16];
      2'd2: byte_sel = word_q[15:8];
      2'd3: byte_sel = word_q[7:0];
      default: byte_sel = word_q[31:24];
    endcase
  end

  // All port outputs decode from registered state, so they are stable across
  // the whole cycle and safe for the falling-edge memory capture.
  always_comb begin
    cpu_stall = (state != S_IDLE);
    wr_ready  = (state == S_ACCEPT);
    mem_we    = (state == S_WRITE);
    load_done = (state == S_DONE);
    mem_addr  = (state == S_IDLE) ? pc_addr : ptr;
    mem_data  = (state == S_WRITE) ? DATA_WIDTH'(byte_sel) : '0;
  end

  assign load_err   = err_q;
  assign byte_count = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= '0;
      cnt    <= '0;
      idx    <= '0;
      word_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
            state <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (wr_valid) begin
            // Reject the whole word up front so no partial word is written.
            if (overflow) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              word_q <= wr_word;
              last_q <= wr_last;
              idx    <= '0;
              state  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          ptr <= ptr + ADDR_WIDTH'(1);
          cnt <= cnt + ADDR_WIDTH'(1);
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= last_q ? S_DONE : S_ACCEPT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader. A cycle table covers
// the basic two-word load; hand-written sequences cover reset mid-load and
// the overflow boundary; randomized sessions are checked against a
// word-level model of what the host sent.
module tb_imem_loader;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int DEPTH = 91;
  localparam int CAP   = DEPTH / 4;   // whole words that fit below DEPTH

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          wr_valid;
  logic          wr_ready;
  logic [31:0]   wr_word;
  logic          wr_last;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          cpu_stall;
  logic          load_done;
  logic          load_err;
  logic [AW-1:0] byte_count;

  imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_word(wr_word), .wr_last(wr_last),
    .pc_addr(pc_addr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .cpu_stall(cpu_stall), .load_done(load_done),
    .load_err(load_err), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory write log, captured on the falling edge like the real memory.
  logic [31:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          oob_cnt = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_data);
      if (mem_addr >= DEPTH) oob_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        s_start;
    logic        s_valid;
    logic [31:0] s_word;
    logic        s_last;
    logic [31:0] s_pc;
    logic        e_stall;
    logic        e_ready;
    logic        e_we;
    logic        e_done;
    logic        chk_ad;
    logic [31:0] e_addr;
    logic [7:0]  e_data;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t v(logic s, logic va, logic [31:0] w, logic l, logic [31:0] pc,
                             logic st, logic rd, logic we, logic dn,
                             logic ca, logic [31:0] ad, logic [7:0] da, logic [31:0] cn);
    vec_t r;
    r.s_start = s;  r.s_valid = va; r.s_word = w;  r.s_last = l;  r.s_pc = pc;
    r.e_stall = st; r.e_ready = rd; r.e_we = we;   r.e_done = dn;
    r.chk_ad = ca;  r.e_addr = ad;  r.e_data = da; r.e_cnt = cn;
    return r;
  endfunction

  vec_t tbl[13];

  // One load session driven by a host that may insert gaps; the expected
  // outcome comes from the word list and the capacity rule only.
  task automatic run_session(input int n, input int last, input int gap_pct,
                             input bit valid_with_start, input bit start_in_write,
                             input string tag);
    logic [31:0] words[$];
    int idx = 0, cyc = 0, gaps = 0, stall_n = 0, rdy_lo = 0, done_n = 0;
    int acc, exp_err, bad, lim;
    bit hold = 0, started_w = 0, fin = 0, fire;
    logic [7:0] eb;
    logic [31:0] pc;
    for (int i = 0; i < n; i++) words.push_back($urandom);
    if (last >= 0 && last < CAP) begin
      acc = last + 1; exp_err = 0;
    end else begin
      acc = CAP; exp_err = 1;
    end
    wa_q.delete(); wd_q.delete(); oob_cnt = 0;

    start = 1'b1;
    if (valid_with_start) begin
      wr_valid = 1'b1; wr_word = words[0]; wr_last = (last == 0); hold = 1;
    end
    step();
    start = 1'b0;
    chk({tag, ".err_cleared"}, load_err, 0);

    while (!fin && cyc < 1000) begin
      if (!hold && idx < n && $urandom_range(0, 99) >= gap_pct) hold = 1;
      if (hold) begin
        wr_valid = 1'b1; wr_word = words[idx]; wr_last = (idx == last);
      end else if (!wr_ready) begin
        wr_valid = 1'($urandom_range(0, 1)); wr_word = $urandom; wr_last = 1'($urandom_range(0, 1));
      end else begin
        wr_valid = 1'b0;
      end
      if (start_in_write && !started_w && mem_we === 1'b1) begin
        start = 1'b1; started_w = 1;
      end else begin
        start = 1'b0;
      end
      fire = wr_valid && wr_ready;
      if (wr_ready && !wr_valid) gaps++;
      if (cpu_stall) stall_n++;
      if (!wr_ready) rdy_lo++;
      if (load_done) begin done_n++; fin = 1; end
      step();
      if (fire) begin idx++; hold = 0; end
      cyc++;
    end
    wr_valid = 1'b0; start = 1'b0;

    chk({tag, ".done_pulses"}, done_n, 1);
    chk({tag, ".stall_cycles"}, stall_n, 5 * acc + gaps + exp_err + 1);
    chk({tag, ".ready_low_cycles"}, rdy_lo, 4 * acc + 1);
    chk({tag, ".stall_after_done"}, cpu_stall, 0);
    chk({tag, ".load_err"}, load_err, exp_err);
    chk({tag, ".byte_count"}, byte_count, 4 * acc);
    chk({tag, ".write_count"}, wa_q.size(), 4 * acc);
    chk({tag, ".oob_writes"}, oob_cnt, 0);
    bad = 0;
    lim = (wa_q.size() < 4 * acc) ? wa_q.size() : 4 * acc;
    for (int k = 0; k < lim; k++) begin
      eb = 8'(words[k / 4] >> (24 - 8 * (k % 4)));
      if (wa_q[k] !== k || wd_q[k] !== eb) begin
        if (bad == 0)
          $display("  %s write %0d: addr 0x%0h data 0x%0h, want addr 0x%0h data 0x%0h",
                   tag, k, wa_q[k], wd_q[k], k, eb);
        bad++;
      end
    end
    chk({tag, ".write_stream_bad"}, bad, 0);

    // Results hold in IDLE while the CPU address passes through.
    for (int k = 0; k < 2; k++) begin
      pc = $urandom_range(0, DEPTH - 1);
      pc_addr = pc;
      #1;
      chk({tag, ".idle_passthrough"}, mem_addr, pc);
      step();
    end
    chk({tag, ".count_held"}, byte_count, 4 * acc);
    chk({tag, ".err_held"}, load_err, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_word = '0; wr_last = 1'b0;
    pc_addr = 32'h1234;
    repeat (3) step();
    chk("reset.stall", cpu_stall, 0);
    chk("reset.ready", wr_ready, 0);
    chk("reset.we", mem_we, 0);
    chk("reset.data", mem_data, 0);
    chk("reset.done", load_done, 0);
    chk("reset.err", load_err, 0);
    chk("reset.count", byte_count, 0);
    chk("reset.addr", mem_addr, 32'h1234);
    rst_n = 1'b1;
    step();

    // Basic two-word load, cycle by cycle.
    tbl[0]  = v(1, 0, 0,            0, 'h10, 0, 0, 0, 0, 1, 'h10, 8'h00, 0);
    tbl[1]  = v(0, 1, 32'h00500093, 0, 'h10, 1, 1, 0, 0, 0, 0,    8'h00, 0);
    tbl[2]  = v(0, 0, 0,            0, 'h10, 1, 0, 1, 0, 1, 0,    8'h00, 0);
    tbl[3]  = v(0, 0, 0,            0, 'h10, 1, 0, 1, 0, 1, 1,    8'h50, 1);
    tbl[4]  = v(0, 0, 0,            0, 'h10, 1, 0, 1, 0, 1, 2,    8'h00, 2);
    tbl[5]  = v(0, 0, 0,            0, 'h10, 1, 0, 1, 0, 1, 3,    8'h93, 3);
    tbl[6]  = v(0, 1, 32'h00A00113, 1, 'h10, 1, 1, 0, 0, 0, 0,    8'h00, 4);
    tbl[7]  = v(0, 0, 0,            0, 'h10, 1, 0, 1, 0, 1, 4,    8'h00, 4);
    tbl[8]  = v(0, 0, 0,            0, 'h10, 1, 0, 1, 0, 1, 5,    8'hA0, 5);
    tbl[9]  = v(0, 0, 0,            0, 'h10, 1, 0, 1, 0, 1, 6,    8'h01, 6);
    tbl[10] = v(0, 0, 0,            0, 'h10, 1, 0, 1, 0, 1, 7,    8'h13, 7);
    tbl[11] = v(0, 0, 0,            0, 'h10, 1, 0, 0, 1, 0, 0,    8'h00, 8);
    tbl[12] = v(0, 0, 0,            0, 'h20, 0, 0, 0, 0, 1, 'h20, 8'h00, 8);
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].s_start; wr_valid = tbl[i].s_valid; wr_word = tbl[i].s_word;
      wr_last = tbl[i].s_last; pc_addr = tbl[i].s_pc;
      #1;
      chk($sformatf("tbl[%0d].stall", i), cpu_stall, tbl[i].e_stall);
      chk($sformatf("tbl[%0d].ready", i), wr_ready, tbl[i].e_ready);
      chk($sformatf("tbl[%0d].we", i), mem_we, tbl[i].e_we);
      chk($sformatf("tbl[%0d].done", i), load_done, tbl[i].e_done);
      chk($sformatf("tbl[%0d].count", i), byte_count, tbl[i].e_cnt);
      if (tbl[i].chk_ad) begin
        chk($sformatf("tbl[%0d].addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("tbl[%0d].data", i), mem_data, tbl[i].e_data);
      end
      step();
    end
    start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    chk("basic.load_err", load_err, 0);

    // Reset during the second WRITE cycle of a word.
    wa_q.delete(); wd_q.delete();
    pc_addr = 32'h44;
    start = 1'b1; step(); start = 1'b0;
    wr_valid = 1'b1; wr_word = 32'hDEADBEEF; wr_last = 1'b0;
    step(); wr_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid.we", mem_we, 0);
    chk("rst_mid.stall", cpu_stall, 0);
    chk("rst_mid.count", byte_count, 0);
    chk("rst_mid.addr", mem_addr, 32'h44);
    rst_n = 1'b1;
    step();
    chk("rst_mid.writes", wa_q.size(), 2);
    if (wa_q.size() >= 2) begin
      chk("rst_mid.addr0", wa_q[0], 0);
      chk("rst_mid.data0", wd_q[0], 8'hDE);
      chk("rst_mid.addr1", wa_q[1], 1);
      chk("rst_mid.data1", wd_q[1], 8'hAD);
    end

    run_session(5, 4, 0, 0, 0, "backpressure");
    run_session(CAP + 1, -1, 0, 0, 0, "overflow");
    run_session(3, 2, 0, 1, 0, "valid_with_start");
    run_session(4, 3, 10, 0, 1, "start_in_write");
    run_session(CAP, CAP - 1, 0, 0, 0, "exact_fit");
    run_session(CAP + 3, -1, 25, 0, 1, "overflow_gaps");
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      run_session(n, $urandom_range(0, n - 1), $urandom_range(0, 50),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and address arbiter for the byte-wide instruction memory. It accepts 32-bit instruction words from a host over a valid/ready handshake and writes each word into memory as four bytes, most significant byte first. This matches the fetch path, which assembles `{mem[a], mem[a+1], mem[a+2], mem[a+3]}`. While a load is in progress the block stalls the CPU and owns the memory address/write port; otherwise it passes the CPU fetch address straight through.

## Interface
- `DATA_WIDTH`, 8: memory byte width.
- `ADDR_WIDTH`, 32: memory address width.
- `MEM_DEPTH`, 91: number of bytes in instruction memory (valid addresses 0..MEM_DEPTH-1).

- `clk`  in  1: single clock. All state updates on the rising edge; memory samples write signals on the falling edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1: begin a load session at byte address 0.
- `wr_valid`  in  1: host word valid.
- `wr_ready`  out  1: loader can accept a word.
- `wr_word`  in  32: instruction word.
- `wr_last`  in  1: qualifies `wr_word` as the final word of the program.
- `pc_addr`  in  ADDR_WIDTH: CPU fetch address.
- `mem_addr`  out  ADDR_WIDTH: to memory `addr`.
- `mem_data`  out  DATA_WIDTH: to memory `data`.
- `mem_we`  out  1: to memory `we`.
- `cpu_stall`  out  1: freezes PC/pipeline while high.
- `load_done`  out  1: one-cycle pulse at the end of a session.
- `load_err`  out  1: sticky overflow flag, cleared by `start` or reset.
- `byte_count`  out  ADDR_WIDTH: bytes written in the current or last session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE. Internal registers:
  - `ptr` (next byte address)
  - `idx` (2-bit byte index)
  - `word_q` (latched word)
  - `last_q` (latched `wr_last`)
- IDLE:
  - Outputs: `cpu_stall`=0, `wr_ready`=0, `mem_we`=0.
  - `mem_addr`=`pc_addr` (combinational passthrough); `mem_data`=0.
  - On `start`: `ptr`←0, `byte_count`←0, `load_err`←0, go to ACCEPT.
- ACCEPT:
  - Outputs: `cpu_stall`=1, `wr_ready`=1, `mem_we`=0.
  - On `wr_valid`:
    - If `ptr+3 > MEM_DEPTH-1`: discard the word, set `load_err`, go to DONE.
    - Otherwise: `word_q`←`wr_word`, `last_q`←`wr_last`, `idx`←0, go to WRITE.
- WRITE:
  - Outputs: `cpu_stall`=1, `wr_ready`=0, `mem_we`=1, `mem_addr`=`ptr`.
  - `mem_data` = `word_q[31-8*idx -: 8]`.
  - Each cycle: `ptr`++, `byte_count`++, `idx`++.
  - After `idx`==3: go to DONE if `last_q` is set, else to ACCEPT.
- DONE:
  - Outputs: `cpu_stall`=1, `load_done`=1 for this one cycle, `mem_we`=0.
  - Next state: IDLE.
- `start` is ignored outside IDLE. `wr_valid` is ignored outside ACCEPT; the host must hold the word until `wr_ready`.
- `start` and `wr_valid` in the same IDLE cycle: only `start` takes effect, and the word is taken in the following ACCEPT cycle.
- `ptr` is never wrapped. Overflow is detected before any byte of the offending word is written, so memory never receives an out-of-range address.
- `byte_count` and `load_err` hold their values in IDLE until the next `start`.

## Timing
- Reset values:
  - State IDLE; `ptr`=0, `idx`=0, `byte_count`=0.
  - `load_err`=0, `load_done`=0, `mem_we`=0, `mem_data`=0, `cpu_stall`=0, `wr_ready`=0.
  - `mem_addr`=`pc_addr`.
- Reset mid-load: abort on the next rising edge. Bytes already written stay in memory.
- `mem_we`, `mem_data` and `mem_addr` are driven from registered state during WRITE. They are stable for the whole cycle, so memory captures them at the falling edge of the same cycle.
- Per word: 1 ACCEPT cycle + 4 WRITE cycles, so at most 1 word per 5 cycles.
- An N-word program takes 5N+1 cycles from the first ACCEPT, counting DONE.
- `cpu_stall` rises the cycle after `start` and falls the cycle after DONE.

## Test plan
- Basic load:
  - Stimulus: `start`, then 0x00500093 followed by 0x00A00113 with `wr_last` on the second word.
  - Response: bytes 0..7 = 00,50,00,93,00,A0,01,13 on consecutive WRITE cycles; `load_done` pulses once; `byte_count`=8; `cpu_stall` high for 11 cycles.
- Backpressure:
  - Stimulus: `wr_valid` held high continuously.
  - Response: `wr_ready` low for exactly 4 cycles after each accept; no word is duplicated or lost.
- Overflow:
  - Stimulus: with `MEM_DEPTH`=91, send 23 words, `wr_last` never set.
  - Response: 22 words land at 0..87; the 23rd is rejected (`ptr`=88, 88+3>90); `load_err`=1; `load_done` pulses; `mem_we` never asserts at an address ≥88.
- Reset mid-load:
  - Stimulus: `rst_n`=0 during the second WRITE cycle of a word.
  - Response: next cycle is IDLE with `mem_we`=0, `cpu_stall`=0, `byte_count`=0; the bytes already written remain in memory.
- Passthrough and ignored start:
  - Stimulus: in IDLE, `pc_addr`=0x10; then pulse `start` during WRITE.
  - Response: in IDLE, `mem_addr`=0x10 and `mem_we`=0 in the same cycle; the `start` pulse during WRITE has no effect on `ptr` or `load_err`.
